// File: rtl/ieeedrv_sdarb_if.sv
// Requester and HPS SD channel bundle for the SD arbiter.
// The slave modport is the arbiter's view; master is the environment.
interface ieeedrv_sdarb_if #(
   parameter int PORTS = 2
);
   logic [31:0]      req_lba     [PORTS];
   logic [5:0]       req_blk_cnt [PORTS];
   logic [7:0]       req_buff_din[PORTS];
   logic [PORTS-1:0] req_rd;
   logic [PORTS-1:0] req_wr;
   logic [PORTS-1:0] req_ack;
   logic [PORTS-1:0] req_buff_wr;
   logic [31:0]      sd_lba;
   logic [5:0]       sd_blk_cnt;
   logic             sd_rd;
   logic             sd_wr;
   logic             sd_ack;
   logic             sd_buff_wr;
   logic [7:0]       sd_buff_din;
   logic             timeout;
   logic [2:0]       grant;

   modport slave (
      input  req_lba, req_blk_cnt, req_buff_din,
      input  req_rd, req_wr,
      input  sd_ack, sd_buff_wr,
      output req_ack, req_buff_wr,
      output sd_lba, sd_blk_cnt, sd_rd, sd_wr,
      output sd_buff_din, timeout, grant
   );

   modport master (
      output req_lba, req_blk_cnt, req_buff_din,
      output req_rd, req_wr,
      output sd_ack, sd_buff_wr,
      input  req_ack, req_buff_wr,
      input  sd_lba, sd_blk_cnt, sd_rd, sd_wr,
      input  sd_buff_din, timeout, grant
   );
endinterface

// File: rtl/ieeedrv_sdarb.sv
// Round-robin arbiter of drive-unit SD block requests onto the
// single HPS SD channel, with ack/strobe/data routing and timeout.
module ieeedrv_sdarb #(
   parameter int          PORTS   = 2,
   parameter logic [23:0] TIMEOUT = 24'd16_000_000
) (
   input logic             clk_sys,
   input logic             reset,
   ieeedrv_sdarb_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;

   logic [1:0]  r_state;
   logic [2:0]  r_grant;
   logic [2:0]  r_rr_ptr;
   logic [31:0] r_lba;
   logic [5:0]  r_cnt;
   logic        r_sd_rd;
   logic        r_sd_wr;
   logic        r_timeout;
   logic [23:0] r_tcnt;

   logic        w_hit;
   logic [2:0]  w_sel;
   logic        w_sel_wr;
   logic [31:0] w_sel_lba;
   logic [5:0]  w_sel_cnt;
   logic [2:0]  w_next;
   logic        w_xfer;

   // First pending port at or after rr_ptr, wrapping modulo PORTS.
   always_comb begin
      int j;
      j         = 0;
      w_hit     = 1'b0;
      w_sel     = r_rr_ptr;
      w_sel_wr  = 1'b0;
      w_sel_lba = '0;
      w_sel_cnt = '0;
      for (int i = 0; i < PORTS; i++) begin
         j = int'(r_rr_ptr) + i;
         if (j >= PORTS)
            j = j - PORTS;
         for (int g = 0; g < PORTS; g++) begin
            if (g == j && !w_hit &&
                (bus.req_rd[g] | bus.req_wr[g])) begin
               w_hit     = 1'b1;
               w_sel     = 3'(g);
               w_sel_wr  = bus.req_wr[g];
               w_sel_lba = bus.req_lba[g];
               w_sel_cnt = bus.req_blk_cnt[g];
            end
         end
      end
   end

   assign w_next = (r_grant == 3'(PORTS - 1)) ?
                   3'd0 : r_grant + 3'd1;
   assign w_xfer = (r_state == S_XFER);

   always_comb begin
      bus.req_ack     = '0;
      bus.req_buff_wr = '0;
      bus.sd_buff_din = '0;
      for (int g = 0; g < PORTS; g++) begin
         if (3'(g) == r_grant) begin
            bus.req_ack[g]     = bus.sd_ack & w_xfer;
            bus.req_buff_wr[g] = bus.sd_buff_wr & w_xfer;
            bus.sd_buff_din    = bus.req_buff_din[g];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_rr_ptr  <= '0;
         r_lba     <= '0;
         r_cnt     <= '0;
         r_sd_rd   <= 1'b0;
         r_sd_wr   <= 1'b0;
         r_timeout <= 1'b0;
         r_tcnt    <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  r_grant <= w_sel;
                  r_lba   <= w_sel_lba;
                  r_cnt   <= w_sel_cnt;
                  r_sd_wr <= w_sel_wr;
                  r_sd_rd <= ~w_sel_wr;
                  r_tcnt  <= '0;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.sd_ack) begin
                  r_sd_rd <= 1'b0;
                  r_sd_wr <= 1'b0;
                  r_state <= S_XFER;
               end else if (TIMEOUT != 24'd0 &&
                            r_tcnt == TIMEOUT) begin
                  r_sd_rd   <= 1'b0;
                  r_sd_wr   <= 1'b0;
                  r_timeout <= 1'b1;
                  r_rr_ptr  <= w_next;
                  r_state   <= S_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + 24'd1;
               end
            end
            S_XFER: begin
               if (!bus.sd_ack) begin
                  r_rr_ptr <= w_next;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.sd_lba     = r_lba;
   assign bus.sd_blk_cnt = r_cnt;
   assign bus.sd_rd      = r_sd_rd;
   assign bus.sd_wr      = r_sd_wr;
   assign bus.timeout    = r_timeout;
   assign bus.grant      = r_grant;

endmodule

// File: tb/tb_ieeedrv_sdarb.sv
// Directed bench for ieeedrv_sdarb: vector table of single
// transactions plus contention, timeout and reset sequences.
module tb_ieeedrv_sdarb;

   localparam int          PORTS = 2;
   localparam logic [23:0] TMO   = 24'd10;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;

   always #5 clk_sys = ~clk_sys;

   ieeedrv_sdarb_if #(.PORTS(PORTS)) bus ();

   ieeedrv_sdarb #(
      .PORTS   (PORTS),
      .TIMEOUT (TMO)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   typedef struct {
      int          port;
      logic        rd;
      logic        wr;
      logic [31:0] lba;
      logic [5:0]  cnt;
      logic [7:0]  din0;
      logic [7:0]  din1;
      int          strobes;
      logic        exp_rd;
      logic        exp_wr;
      logic [7:0]  exp_din;
   } vec_t;

   vec_t vecs[4];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h",
                  name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input int p, input logic rd, input logic wr,
      input logic [31:0] lba, input logic [5:0] cnt,
      input logic [7:0] d0, input logic [7:0] d1,
      input int st, input logic erd, input logic ewr,
      input logic [7:0] edin);
      vec_t v;
      v.port = p;   v.rd = rd;     v.wr = wr;
      v.lba = lba;  v.cnt = cnt;
      v.din0 = d0;  v.din1 = d1;   v.strobes = st;
      v.exp_rd = erd; v.exp_wr = ewr; v.exp_din = edin;
      return v;
   endfunction

   task automatic xact(input vec_t v);
      int c0;
      int c1;
      c0 = 0;
      c1 = 0;
      bus.req_buff_din[0]      = v.din0;
      bus.req_buff_din[1]      = v.din1;
      bus.req_lba[v.port]      = v.lba;
      bus.req_blk_cnt[v.port]  = v.cnt;
      bus.req_rd[v.port]       = v.rd;
      bus.req_wr[v.port]       = v.wr;
      tick();
      chk("req_sd_rd", 32'(bus.sd_rd), 32'(v.exp_rd));
      chk("req_sd_wr", 32'(bus.sd_wr), 32'(v.exp_wr));
      chk("req_lba", bus.sd_lba, v.lba);
      chk("req_cnt", 32'(bus.sd_blk_cnt), 32'(v.cnt));
      chk("req_grant", 32'(bus.grant), 32'(v.port));
      bus.sd_buff_wr = 1'b1;
      #1;
      chk("req_strobe_drop", 32'(bus.req_buff_wr), 32'd0);
      bus.sd_buff_wr = 1'b0;
      bus.sd_ack = 1'b1;
      bus.req_rd[v.port] = 1'b0;
      bus.req_wr[v.port] = 1'b0;
      tick();
      chk("xfer_sd_rd", 32'(bus.sd_rd), 32'd0);
      chk("xfer_sd_wr", 32'(bus.sd_wr), 32'd0);
      chk("xfer_ack", 32'(bus.req_ack), 32'd1 << v.port);
      chk("xfer_din", 32'(bus.sd_buff_din), 32'(v.exp_din));
      for (int s = 0; s < v.strobes; s++) begin
         bus.sd_buff_wr = 1'b1;
         #1;
         c0 += int'(bus.req_buff_wr[0]);
         c1 += int'(bus.req_buff_wr[1]);
         tick();
         bus.sd_buff_wr = 1'b0;
         tick();
      end
      chk("strobe_p0", 32'(c0),
          (v.port == 0) ? 32'(v.strobes) : 32'd0);
      chk("strobe_p1", 32'(c1),
          (v.port == 1) ? 32'(v.strobes) : 32'd0);
      bus.sd_ack = 1'b0;
      tick();
      chk("end_ack", 32'(bus.req_ack), 32'd0);
      tick();
   endtask

   initial begin
      bus.req_rd     = '0;
      bus.req_wr     = '0;
      bus.sd_ack     = 1'b0;
      bus.sd_buff_wr = 1'b0;
      for (int p = 0; p < PORTS; p++) begin
         bus.req_lba[p]      = '0;
         bus.req_blk_cnt[p]  = '0;
         bus.req_buff_din[p] = '0;
      end

      vecs[0] = mk(0, 1, 0, 32'h165, 6'd3, 8'h00, 8'h00,
                   4, 1, 0, 8'h00);
      vecs[1] = mk(1, 0, 1, 32'h1000, 6'd0, 8'h00, 8'hA5,
                   2, 0, 1, 8'hA5);
      vecs[2] = mk(0, 1, 1, 32'hDEADBEEF, 6'd63, 8'h3C, 8'h11,
                   1, 0, 1, 8'h3C);
      vecs[3] = mk(1, 1, 0, 32'h7, 6'd1, 8'h22, 8'h5A,
                   3, 1, 0, 8'h5A);

      reset = 1'b1;
      tick();
      tick();
      chk("rst_sd_rd", 32'(bus.sd_rd), 32'd0);
      chk("rst_sd_wr", 32'(bus.sd_wr), 32'd0);
      chk("rst_lba", bus.sd_lba, 32'd0);
      chk("rst_cnt", 32'(bus.sd_blk_cnt), 32'd0);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_timeout", 32'(bus.timeout), 32'd0);
      chk("rst_ack", 32'(bus.req_ack), 32'd0);
      chk("rst_bwr", 32'(bus.req_buff_wr), 32'd0);
      reset = 1'b0;
      tick();

      foreach (vecs[i]) xact(vecs[i]);

      // Contention: rr_ptr is 0 after the last port-1 transfer.
      bus.req_lba[0] = 32'h100;
      bus.req_lba[1] = 32'h200;
      bus.req_rd     = 2'b11;
      tick();
      chk("cont_g0", 32'(bus.grant), 32'd0);
      chk("cont_lba0", bus.sd_lba, 32'h100);
      bus.sd_ack    = 1'b1;
      bus.req_rd[0] = 1'b0;
      tick();
      chk("cont_ack0", 32'(bus.req_ack), 32'b01);
      bus.sd_ack = 1'b0;
      tick();
      chk("cont_gap0", 32'(bus.sd_rd), 32'd0);
      bus.req_rd[0] = 1'b1;
      tick();
      chk("cont_g1", 32'(bus.grant), 32'd1);
      chk("cont_lba1", bus.sd_lba, 32'h200);
      chk("cont_rd1", 32'(bus.sd_rd), 32'd1);
      bus.sd_ack    = 1'b1;
      bus.req_rd[1] = 1'b0;
      tick();
      chk("cont_ack1", 32'(bus.req_ack), 32'b10);
      bus.sd_ack = 1'b0;
      tick();
      chk("cont_gap1", 32'(bus.sd_rd), 32'd0);
      tick();
      chk("cont_g0b", 32'(bus.grant), 32'd0);
      chk("cont_rd0b", 32'(bus.sd_rd), 32'd1);
      bus.sd_ack    = 1'b1;
      bus.req_rd[0] = 1'b0;
      tick();
      bus.sd_ack = 1'b0;
      tick();
      tick();

      // Timeout: rr_ptr is 1, both pending, port 1 never acked.
      bus.req_lba[0] = 32'h55;
      bus.req_rd     = 2'b11;
      tick();
      chk("tmo_grant", 32'(bus.grant), 32'd1);
      chk("tmo_rd", 32'(bus.sd_rd), 32'd1);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("tmo_early", 32'(bus.timeout), 32'd0);
      end
      chk("tmo_hold_rd", 32'(bus.sd_rd), 32'd1);
      tick();
      chk("tmo_pulse", 32'(bus.timeout), 32'd1);
      chk("tmo_drop_rd", 32'(bus.sd_rd), 32'd0);
      bus.req_rd[1] = 1'b0;
      tick();
      chk("tmo_pulse_end", 32'(bus.timeout), 32'd0);
      chk("tmo_next_g", 32'(bus.grant), 32'd0);
      chk("tmo_next_rd", 32'(bus.sd_rd), 32'd1);
      chk("tmo_next_lba", bus.sd_lba, 32'h55);
      bus.sd_ack    = 1'b1;
      bus.req_rd[0] = 1'b0;
      tick();
      chk("pre_rst_ack", 32'(bus.req_ack), 32'b01);

      // Reset in XFER with sd_ack and strobes still active.
      reset          = 1'b1;
      bus.sd_buff_wr = 1'b1;
      tick();
      chk("mid_rst_ack", 32'(bus.req_ack), 32'd0);
      chk("mid_rst_rd", 32'(bus.sd_rd), 32'd0);
      chk("mid_rst_bwr", 32'(bus.req_buff_wr), 32'd0);
      chk("mid_rst_lba", bus.sd_lba, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("post_rst_ack", 32'(bus.req_ack), 32'd0);
         chk("post_rst_bwr", 32'(bus.req_buff_wr), 32'd0);
         chk("post_rst_rd", 32'(bus.sd_rd), 32'd0);
      end
      bus.sd_ack     = 1'b0;
      bus.sd_buff_wr = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d",
               n_chk, n_fail);
      $finish;
   end

endmodule
